dab_waveform_meter: RTL and testbench

- Measurement end of the DAB modulation path. Samples the three-level bridge voltage codes V1/V2 (-1/0/+1), as driven by the phase-shift waveform generator or by a comparator front end.
- Recovers the modulation timing in clock counts: period (2·pi), positive and negative pulse widths of V1, positive pulse width of V2, and signed phase shift phi.
- Used for closed-loop checking of the modulator and for oscilloscope-free bench verification.
- Counts are in the same units as the generator's tau/phi/pi counts.

---
 rtl/dab_waveform_meter.sv | 200 ++++++++++++++++++++
 tb/tb_dab_waveform_meter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dab_waveform_meter.sv
// Measures the DAB bridge waveforms V1/V2: period, pulse widths and signed phase
// shift, published once per V1 period after the meter has locked onto the waveform.
module dab_waveform_meter #(
  parameter int CNT_W     = 19,
  parameter int MAX_COUNT = 262143,
  parameter int ASYM_TOL  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CE,
  input  logic [1:0]       V1,
  input  logic [1:0]       V2,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] tau1_cnt,
  output logic [CNT_W-1:0] tau1n_cnt,
  output logic [CNT_W-1:0] tau2_cnt,
  output logic [CNT_W-1:0] phi_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic             err_asym
);

  localparam logic [1:0]       C_POS = 2'b01;
  localparam logic [1:0]       C_NEG = 2'b11;
  localparam logic [1:0]       C_ILL = 2'b10;
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TOL = CNT_W'(ASYM_TOL);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x >= C_MAX) ? C_MAX : x + C_ONE;
  endfunction

  // Channel 0 carries V1, channel 1 carries V2.
  logic [1:0] w_v_in [2];
  logic [1:0] r_v_s  [2];
  logic [1:0] r_v_q  [2];
  logic [1:0] w_pos_rise;
  logic [1:0] w_pos_fall;
  logic [1:0] w_ill;

  assign w_v_in[0] = V1;
  assign w_v_in[1] = V2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign w_pos_rise[gi] = CE && (r_v_s[gi] == C_POS) && (r_v_q[gi] != C_POS);
      assign w_pos_fall[gi] = CE && (r_v_s[gi] != C_POS) && (r_v_q[gi] == C_POS);
      assign w_ill[gi]      = CE && (r_v_s[gi] == C_ILL);
    end
  endgenerate

  logic w_e1, w_f1, w_n1, w_m1, w_e2, w_f2;
  assign w_e1 = w_pos_rise[0];
  assign w_f1 = w_pos_fall[0];
  assign w_n1 = CE && (r_v_s[0] == C_NEG) && (r_v_q[0] != C_NEG);
  assign w_m1 = CE && (r_v_s[0] != C_NEG) && (r_v_q[0] == C_NEG);
  assign w_e2 = w_pos_rise[1];
  assign w_f2 = w_pos_fall[1];

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt, r_cntf, r_cnt2;
  logic [CNT_W-1:0] r_tau1, r_tau1n, r_tau2, r_neg_start, r_d;
  logic             r_seen_f1, r_seen_m1, r_seen_f2;
  logic [CNT_W-1:0] r_period, r_tau1_o, r_tau1n_o, r_tau2_o, r_phi;
  logic             r_meas_valid, r_locked, r_err_illegal, r_err_timeout, r_err_asym;

  // Stamps that land on the E1 cycle itself still belong to the period that E1 closes,
  // so the publish path sees them through these bypass values.
  logic [CNT_W-1:0] w_tau1n_now, w_tau1n_eff, w_tau2_eff, w_d_new, w_d_eff;
  logic [CNT_W-1:0] w_phi, w_asym_diff;
  logic             w_seen_all, w_publish, w_timeout, w_illegal, w_asym;

  assign w_tau1n_now = r_cnt - r_neg_start;
  assign w_tau1n_eff = w_m1 ? w_tau1n_now : r_tau1n;
  assign w_tau2_eff  = w_f2 ? r_cnt2 : r_tau2;
  assign w_d_new     = w_f1 ? '0 : r_cntf;
  assign w_d_eff     = w_f2 ? w_d_new : r_d;

  assign w_seen_all = r_seen_f1 && (r_seen_m1 || w_m1) && (r_seen_f2 || w_f2);
  assign w_publish  = w_e1 && (r_state == S_RUN) && w_seen_all;
  assign w_timeout  = CE && !w_e1 && (r_cnt == C_MAX);
  assign w_illegal  = |w_ill;

  // Delays of half a period or more are reported as negative (lag) values.
  assign w_phi       = (w_d_eff >= (r_cnt >> 1)) ? (w_d_eff - r_cnt) : w_d_eff;
  assign w_asym_diff = (r_tau1 >= w_tau1n_eff) ? (r_tau1 - w_tau1n_eff) : (w_tau1n_eff - r_tau1);
  assign w_asym      = (w_asym_diff > C_TOL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_s[0]      <= '0;
      r_v_s[1]      <= '0;
      r_v_q[0]      <= '0;
      r_v_q[1]      <= '0;
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cntf        <= '0;
      r_cnt2        <= '0;
      r_tau1        <= '0;
      r_tau1n       <= '0;
      r_tau2        <= '0;
      r_neg_start   <= '0;
      r_d           <= '0;
      r_seen_f1     <= 1'b0;
      r_seen_m1     <= 1'b0;
      r_seen_f2     <= 1'b0;
      r_period      <= '0;
      r_tau1_o      <= '0;
      r_tau1n_o     <= '0;
      r_tau2_o      <= '0;
      r_phi         <= '0;
      r_meas_valid  <= 1'b0;
      r_locked      <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_asym    <= 1'b0;
    end else if (CE) begin
      r_v_s[0] <= w_v_in[0];
      r_v_s[1] <= w_v_in[1];
      r_v_q[0] <= r_v_s[0];
      r_v_q[1] <= r_v_s[1];

      r_cnt  <= w_e1 ? C_ONE : sat_inc(r_cnt);
      r_cntf <= w_f1 ? C_ONE : sat_inc(r_cntf);
      r_cnt2 <= w_e2 ? C_ONE : sat_inc(r_cnt2);

      if (w_f1) r_tau1      <= r_cnt;
      if (w_n1) r_neg_start <= r_cnt;
      if (w_m1) r_tau1n     <= w_tau1n_now;
      if (w_f2) begin
        r_tau2 <= r_cnt2;
        r_d    <= w_d_new;
      end

      if (w_e1) begin
        r_seen_f1 <= 1'b0;
        r_seen_m1 <= 1'b0;
        r_seen_f2 <= 1'b0;
      end else begin
        if (w_f1) r_seen_f1 <= 1'b1;
        if (w_m1) r_seen_m1 <= 1'b1;
        if (w_f2) r_seen_f2 <= 1'b1;
      end

      if (w_timeout) begin
        r_state  <= S_IDLE;
        r_locked <= 1'b0;
      end else if (w_e1) begin
        case (r_state)
          S_IDLE: begin
            r_state  <= S_ARM;
            r_locked <= 1'b0;
          end
          S_ARM, S_RUN: begin
            r_state  <= S_RUN;
            r_locked <= 1'b1;
          end
          default: begin
            r_state  <= S_IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end

      r_meas_valid <= w_publish;
      if (w_publish) begin
        r_period   <= r_cnt;
        r_tau1_o   <= r_tau1;
        r_tau1n_o  <= w_tau1n_eff;
        r_tau2_o   <= w_tau2_eff;
        r_phi      <= w_phi;
        r_err_asym <= w_asym;
      end

      if (w_timeout)      r_err_timeout <= 1'b1;
      else if (w_publish) r_err_timeout <= 1'b0;

      if (w_illegal)      r_err_illegal <= 1'b1;
      else if (w_publish) r_err_illegal <= 1'b0;
    end
  end

  assign period_cnt  = r_period;
  assign tau1_cnt    = r_tau1_o;
  assign tau1n_cnt   = r_tau1n_o;
  assign tau2_cnt    = r_tau2_o;
  assign phi_cnt     = r_phi;
  assign meas_valid  = r_meas_valid;
  assign locked      = r_locked;
  assign err_illegal = r_err_illegal;
  assign err_timeout = r_err_timeout;
  assign err_asym    = r_err_asym;

endmodule

// File: tb/tb_dab_waveform_meter.sv
// Bench for dab_waveform_meter: drives periodic three-level waveforms described by a few
// edge positions and compares each published measurement with values derived from them.
module tb_dab_waveform_meter;

  localparam int CW   = 19;
  localparam int MAXC = 3000;
  localparam int TOL  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce  = 1'b1;
  logic [1:0]    v1  = 2'b00;
  logic [1:0]    v2  = 2'b00;
  logic [CW-1:0] period_cnt, tau1_cnt, tau1n_cnt, tau2_cnt, phi_cnt;
  logic          meas_valid, locked, err_illegal, err_timeout, err_asym;

  dab_waveform_meter #(.CNT_W(CW), .MAX_COUNT(MAXC), .ASYM_TOL(TOL)) dut (
    .clk(clk), .rst(rst), .CE(ce), .V1(v1), .V2(v2),
    .period_cnt(period_cnt), .tau1_cnt(tau1_cnt), .tau1n_cnt(tau1n_cnt),
    .tau2_cnt(tau2_cnt), .phi_cnt(phi_cnt), .meas_valid(meas_valid),
    .locked(locked), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .err_asym(err_asym)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Waveform, in CE ticks within one period: V1 +1 on [0,wa), -1 on [wb,wb+wn),
  // V2 +1 on the circular window [ws2, ws2+ww2).
  int wp, wa, wb, wn, ws2, ww2;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_wave(input int p, input int a, input int b, input int n,
                          input int s2, input int w2);
    wp = p; wa = a; wb = b; wn = n; ws2 = s2; ww2 = w2;
  endtask

  function automatic logic [1:0] wave_v1(input int t);
    int ph;
    ph = t % wp;
    if (ph < wa)                       return 2'b01;
    else if (ph >= wb && ph < wb + wn) return 2'b11;
    else                               return 2'b00;
  endfunction

  function automatic logic [1:0] wave_v2(input int t);
    int ph;
    ph = t % wp;
    return (((ph - ws2 + wp) % wp) < ww2) ? 2'b01 : 2'b00;
  endfunction

  // Phase: delay from V1 leaving +1 to V2 leaving +1, folded into [-P/2, P/2).
  function automatic int exp_phi();
    int d;
    d = (((ws2 + ww2) % wp) - wa + wp) % wp;
    return (d >= wp / 2) ? d - wp : d;
  endfunction

  function automatic int exp_asym();
    int diff;
    diff = (wa > wn) ? wa - wn : wn - wa;
    return (diff > TOL) ? 1 : 0;
  endfunction

  task automatic check_zero();
    chk("rst_period", int'(period_cnt), 0);
    chk("rst_tau1", int'(tau1_cnt), 0);
    chk("rst_tau1n", int'(tau1n_cnt), 0);
    chk("rst_tau2", int'(tau2_cnt), 0);
    chk("rst_phi", int'(phi_cnt), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_illegal", int'(err_illegal), 0);
    chk("rst_timeout", int'(err_timeout), 0);
    chk("rst_asym", int'(err_asym), 0);
  endtask

  task automatic pulse_reset();
    v1  = 2'b00;
    v2  = 2'b00;
    ce  = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero();
  endtask

  task automatic check_meas(input string seg);
    $display("meas %s period=%0d tau1=%0d tau1n=%0d tau2=%0d phi=%0d asym=%0b",
             seg, period_cnt, tau1_cnt, tau1n_cnt, tau2_cnt, $signed(phi_cnt), err_asym);
    chk("period", int'(period_cnt), wp);
    chk("tau1", int'(tau1_cnt), wa);
    chk("tau1n", int'(tau1n_cnt), wn);
    chk("tau2", int'(tau2_cnt), ww2);
    chk("phi", int'($signed(phi_cnt)), exp_phi());
    chk("asym", int'(err_asym), exp_asym());
    chk("locked", int'(locked), 1);
    chk("illegal_clr", int'(err_illegal), 0);
    chk("timeout_clr", int'(err_timeout), 0);
  endtask

  // mode 0: CE always, 1: CE every other clock, 2: random CE. The waveform advances one
  // tick per CE cycle. Every V1 entry into +1 seen after a reset/timeout is an E1; the
  // first two only lock the meter, each later one publishes.
  task automatic run_seg(input string seg, input int kper, input int mode,
                         input int ill_t, input int rst_t);
    int t, ne1, exp_pub, npub;
    logic [1:0] prev, nv1, nv2;
    logic ce_n, ce_prev;
    bit ill_done, rst_done;
    t = 0; ne1 = 0; exp_pub = 0; npub = 0;
    prev = 2'b00; ce_prev = 1'b0; ill_done = 1'b0; rst_done = 1'b0;
    while (t < kper * wp + 10) begin
      case (mode)
        0:       ce_n = 1'b1;
        1:       ce_n = !ce_prev;
        default: ce_n = 1'($urandom_range(0, 1));
      endcase
      if (meas_valid && ce_n) begin
        npub++;
        check_meas(seg);
      end
      if (ill_t >= 0 && !ill_done && t == ill_t + 4) begin
        ill_done = 1'b1;
        chk("illegal_set", int'(err_illegal), 1);
      end
      if (rst_t >= 0 && !rst_done && t == rst_t) begin
        rst_done = 1'b1;
        exp_pub += (ne1 > 2) ? ne1 - 2 : 0;
        ne1 = 0;
        prev = 2'b00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero();
        continue;
      end
      ce = ce_n;
      if (ce_n) begin
        nv1 = wave_v1(t);
        nv2 = (t == ill_t) ? 2'b10 : wave_v2(t);
        if (nv1 == 2'b01 && prev != 2'b01) ne1++;
        prev = nv1;
        v1 = nv1;
        v2 = nv2;
        t++;
      end
      ce_prev = ce_n;
      @(posedge clk);
      #1;
    end
    exp_pub += (ne1 > 2) ? ne1 - 2 : 0;
    chk("npub", npub, exp_pub);
    if (exp_pub > 0) chk("locked_end", int'(locked), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, a, b, n, s2, w2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero();

    // Generator-style waveform, phi=-17.
    set_wave(1000, 300, 500, 300, 995, 288);
    pulse_reset();
    run_seg("lag17", 3, 0, -1, -1);

    set_wave(1000, 300, 500, 300, 129, 288);
    pulse_reset();
    run_seg("lead117", 3, 0, -1, -1);

    // Delay of exactly P/2 folds to -P/2.
    set_wave(1000, 300, 500, 300, 512, 288);
    pulse_reset();
    run_seg("wrap500", 3, 0, -1, -1);

    set_wave(1000, 300, 500, 300, 995, 288);
    pulse_reset();
    run_seg("ce_half", 3, 1, -1, -1);

    set_wave(1000, 300, 500, 305, 995, 288);
    pulse_reset();
    run_seg("asym305", 3, 0, -1, -1);

    set_wave(1000, 300, 500, 302, 995, 288);
    pulse_reset();
    run_seg("asym302", 3, 0, -1, -1);

    // Freeze V1 at 0 until the period counter saturates, then restore the waveform.
    v1 = 2'b00;
    v2 = 2'b00;
    ce = 1'b1;
    repeat (MAXC + 50) @(posedge clk);
    #1;
    chk("timeout_set", int'(err_timeout), 1);
    chk("timeout_unlock", int'(locked), 0);
    set_wave(1000, 300, 500, 300, 995, 288);
    run_seg("restore", 3, 0, 1290, -1);

    // Reset in the V1 zero gap of the second period.
    set_wave(1000, 300, 500, 300, 995, 288);
    pulse_reset();
    run_seg("midrst", 4, 0, -1, 1302);

    for (int i = 0; i < 6; i++) begin
      p  = int'($urandom_range(60, 500));
      a  = int'($urandom_range(6, p / 3));
      b  = a + int'($urandom_range(3, p / 6));
      if ($urandom_range(0, 1) == 1) n = a - 3 + int'($urandom_range(0, 6));
      else                           n = int'($urandom_range(3, p - b - 2));
      s2 = int'($urandom_range(0, p - 1));
      w2 = int'($urandom_range(1, p - 4));
      set_wave(p, a, b, n, s2, w2);
      pulse_reset();
      run_seg("rand", 4, int'($urandom_range(0, 2)), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
